// File: rtl/avalon_master_arbiter_pkg.sv
// Shared types and constants for the Avalon master arbiter and its helpers.
package avalon_pkg;

    localparam int DATA_W = 32;

    localparam int REQ_INSTR = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DEBUG = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } arb_state_t;

    // Index following idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/avalon_master_arbiter_if.sv
// Requester-side and master-side command buses of the arbiter in one bundle.
interface avalon_master_arbiter_if
    import avalon_pkg::*;
#(
    parameter int N = 3,
    parameter int W = DATA_W
);
    logic [N-1:0]   req;
    logic [N-1:0]   req_rnw;
    logic [N*W-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic [W-1:0]   rdata;

    logic           m_start;
    logic           m_rnw;
    logic [W-1:0]   m_addr;
    logic [W-1:0]   m_wdata;
    logic           m_done;
    logic [W-1:0]   m_rdata;

    modport master (
        input  req, req_rnw, req_addr, req_wdata, m_done, m_rdata,
        output req_done, req_err, rdata, m_start, m_rnw, m_addr, m_wdata
    );

    modport slave (
        output req, req_rnw, req_addr, req_wdata, m_done, m_rdata,
        input  req_done, req_err, rdata, m_start, m_rnw, m_addr, m_wdata
    );
endinterface

// File: rtl/avalon_master_arbiter_rr_picker.sv
// Combinational N-way selector: fixed HIPRI first, else round-robin from ptr.
module rr_picker #(
    parameter int  N     = 3,
    parameter int  HIPRI = N,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);
    logic          hi_req;
    logic [IW-1:0] sel;

    if (HIPRI >= 0 && HIPRI < N) begin : g_hi
        assign hi_req = req[HIPRI];
    end else begin : g_no_hi
        assign hi_req = 1'b0;
    end

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sel    = '0;
        // Walk from the far end so the index nearest ptr is assigned last.
        for (int k = N - 1; k >= 0; k--) begin
            sel = IW'((int'(ptr) + k) % N);
            if (req[sel] && int'(sel) != HIPRI) begin
                winner = sel;
                valid  = 1'b1;
            end
        end
        if (hi_req) begin
            winner = IW'(HIPRI);
            valid  = 1'b1;
        end
    end
endmodule

// File: rtl/avalon_master_arbiter.sv
// Shares one avalon_mm_master command port between N requesters, with a
// watchdog that converts a hung slave into an error completion.
module avalon_master_arbiter
    import avalon_pkg::*;
#(
    parameter int  N       = 3,
    parameter int  W       = DATA_W,
    parameter int  HIPRI   = REQ_DEBUG,
    parameter int  TIMEOUT = 1024,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    avalon_master_arbiter_if.master bus,
    output logic [IW-1:0]           grant_id,
    output logic                    busy,
    output logic                    timeout_flag,
    input  logic                    clr_timeout
);
    arb_state_t    state, state_d;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          grant_hi;
    logic [IW-1:0] ptr_next;
    logic [W-1:0]  addr_v  [N];
    logic [W-1:0]  wdata_v [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign addr_v[i]  = bus.req_addr[i*W +: W];
        assign wdata_v[i] = bus.req_wdata[i*W +: W];
    end

    rr_picker #(.N(N), .HIPRI(HIPRI)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    // A completion on the deadline cycle beats the watchdog.
    assign timed_out = (state == WAIT) && !bus.m_done && (cnt == CW'(TIMEOUT));
    assign grant_hi  = (int'(grant_id) == HIPRI);
    assign ptr_next  = IW'(wrap_inc(int'(grant_id), N));
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (bus.m_done)     state_d = RESP;
                else if (timed_out) state_d = DRAIN;
            end
            RESP:    state_d = IDLE;
            DRAIN:   if (bus.m_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr          <= '0;
            cnt          <= '0;
            grant_id     <= '0;
            timeout_flag <= 1'b0;
            bus.m_start  <= 1'b0;
            bus.m_rnw    <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.req_done <= '0;
            bus.req_err  <= '0;
            bus.rdata    <= '0;
        end else begin
            bus.m_start  <= 1'b0;
            bus.req_done <= '0;
            bus.req_err  <= '0;
            if (clr_timeout) timeout_flag <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_vld) begin
                        grant_id    <= pick;
                        bus.m_rnw   <= bus.req_rnw[pick];
                        bus.m_addr  <= addr_v[pick];
                        bus.m_wdata <= wdata_v[pick];
                        bus.m_start <= 1'b1;
                    end
                end
                ISSUE: cnt <= cnt + CW'(1);
                WAIT: begin
                    if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
                    if (bus.m_done) begin
                        if (bus.m_rnw) bus.rdata <= bus.m_rdata;
                        bus.req_done[grant_id] <= 1'b1;
                        if (!grant_hi) ptr <= ptr_next;
                    end else if (timed_out) begin
                        bus.rdata              <= '0;
                        bus.req_done[grant_id] <= 1'b1;
                        bus.req_err[grant_id]  <= 1'b1;
                        timeout_flag           <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Late data is dropped; only the fairness pointer moves.
                    if (bus.m_done && !grant_hi) ptr <= ptr_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds against a
// transaction-level arbitration model.
module tb_avalon_master_arbiter;
    import avalon_pkg::*;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int HI = 2;
    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_flag;
    logic       clr_timeout;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          mptr;
    logic [31:0] mrdata;

    avalon_master_arbiter_if #(.N(N), .W(W)) bus ();

    avalon_master_arbiter #(.N(N), .W(W), .HIPRI(HI), .TIMEOUT(TO)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus.master),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .clr_timeout  (clr_timeout)
    );

    always #5 CLK = ~CLK;

    // Arbitration rule: HIPRI wins if asking, else first index from ptr, wrapping.
    function automatic int ref_pick(input logic [2:0] r, input int p);
        if (r[HI]) return HI;
        for (int k = 0; k < N; k++) begin
            if (((p + k) % N) != HI && r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void note_done(input int g);
        if (g != HI) mptr = (g + 1) % N;
    endfunction

    // Drives one transfer on the master side; reports what the DUT showed.
    task automatic run_xfer(input int lat, input logic [31:0] rd, input logic [2:0] late,
                            input bit drop, output int gid, output logic [31:0] got,
                            output int ts, output bit err, output bit ok,
                            output logic [31:0] ma, output logic mr, output logic [31:0] mw);
        int c;
        ok = 1'b1; err = 1'b0; gid = -1; got = '0; ts = 0; ma = '0; mr = 1'b0; mw = '0;
        c = 0;
        do begin @(negedge CLK); c++; end while (bus.m_start !== 1'b1 && c < 20);
        if (bus.m_start !== 1'b1) begin ok = 1'b0; return; end
        ts = c; gid = int'(grant_id); ma = bus.m_addr; mr = bus.m_rnw; mw = bus.m_wdata;
        bus.req = bus.req | late;
        repeat (lat) @(negedge CLK);
        bus.m_done = 1'b1; bus.m_rdata = rd;
        @(negedge CLK);
        bus.m_done = 1'b0; bus.m_rdata = '0;
        ok  = (bus.req_done === 3'(1 << gid));
        got = bus.rdata;
        err = |bus.req_err;
        if (drop) bus.req[gid] = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_rnw = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.m_done = 1'b0; bus.m_rdata = '0; clr_timeout = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_chk++;
        if (bus.req_done !== 3'b0 || bus.req_err !== 3'b0) begin
            n_fail++; $display("FAIL reset_pulses done=%b err=%b want 000/000", bus.req_done, bus.req_err);
        end
        n_chk++;
        if (bus.m_start !== 1'b0 || busy !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl start=%b busy=%b tflag=%b want 0", bus.m_start, busy, timeout_flag);
        end
        n_chk++;
        if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 || bus.m_rnw !== 1'b0 || bus.rdata !== 32'h0 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_data addr=%h wdata=%h rnw=%b rdata=%h gid=%0d want 0", bus.m_addr, bus.m_wdata, bus.m_rnw, bus.rdata, grant_id);
        end
        RST = 1'b0;
        mptr = 0; mrdata = '0;
        @(negedge CLK);
        n_chk++;
        if (busy !== 1'b0 || bus.m_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle busy=%b start=%b want 0 with no requests", busy, bus.m_start);
        end
    endtask

    task automatic test_single_read();
        int gid, ts, exp; logic [31:0] got, ma, mw; logic mr; bit err, ok;
        @(negedge CLK);
        bus.req_rnw[1] = 1'b1; bus.req_addr[1*W +: W] = 32'h100; bus.req[1] = 1'b1;
        exp = ref_pick(bus.req, mptr);
        run_xfer(3, 32'hDEADBEEF, 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
        n_chk++;
        if (ts !== 1 || gid !== exp) begin
            n_fail++; $display("FAIL single_grant start_lat=%0d gid=%0d want 1/%0d", ts, gid, exp);
        end
        n_chk++;
        if (ma !== 32'h100 || mr !== 1'b1) begin
            n_fail++; $display("FAIL single_cmd addr=%h rnw=%b want 100/1", ma, mr);
        end
        n_chk++;
        if (!ok || got !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++; $display("FAIL single_resp done_ok=%0b rdata=%h err=%b want 1/deadbeef/0", ok, got, err);
        end
        note_done(exp); mrdata = 32'hDEADBEEF;
    endtask

    task automatic test_alternate();
        int gid, ts, exp; logic [31:0] got, ma, mw; logic mr; bit err, ok;
        @(negedge CLK);
        bus.req_rnw[0] = 1'b0; bus.req_rnw[1] = 1'b0;
        bus.req_addr[0*W +: W] = 32'h10; bus.req_addr[1*W +: W] = 32'h20;
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = ref_pick(bus.req, mptr);
            run_xfer(1 + k % 3, $urandom, 3'b000, 1'b0, gid, got, ts, err, ok, ma, mr, mw);
            n_chk++;
            if (!ok || gid !== exp || ts !== ((k == 0) ? 1 : 2) || got !== mrdata || err) begin
                n_fail++; $display("FAIL alternate[%0d] gid=%0d lat=%0d ok=%0b rdata=%h err=%b want gid %0d lat %0d rdata %h",
                                   k, gid, ts, ok, got, err, exp, (k == 0) ? 1 : 2, mrdata);
            end
            note_done(exp);
        end
        bus.req = '0;
    endtask

    task automatic test_hipri();
        int gid, ts, exp; logic [31:0] got, ma, mw; logic mr; bit err, ok;
        logic [31:0] rd;
        @(negedge CLK);
        bus.req_rnw = 3'b111;
        bus.req = 3'b011;
        for (int k = 0; k < 3; k++) begin
            exp = ref_pick(bus.req, mptr);
            rd = $urandom;
            run_xfer(2 + k, rd, (k == 0) ? 3'b100 : 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
            n_chk++;
            if (!ok || gid !== exp || got !== rd || err) begin
                n_fail++; $display("FAIL hipri[%0d] gid=%0d ok=%0b rdata=%h err=%b want gid %0d rdata %h", k, gid, ok, got, err, exp, rd);
            end
            note_done(exp); mrdata = rd;
        end
        bus.req = '0;
    endtask

    task automatic test_random();
        int gid, ts, exp, lat; logic [31:0] got, ma, mw, rd; logic mr; bit err, ok;
        logic [31:0] a [N]; logic [31:0] d [N]; logic rw [N];
        logic [2:0] mask;
        @(negedge CLK);
        mask = 3'($urandom_range(1, 7));
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = $urandom; d[i] = $urandom; rw[i] = 1'($urandom);
                bus.req_addr[i*W +: W] = a[i]; bus.req_wdata[i*W +: W] = d[i]; bus.req_rnw[i] = rw[i];
            end
            bus.req = mask;
            exp = ref_pick(mask, mptr);
            lat = $urandom_range(1, 5);
            rd  = $urandom;
            run_xfer(lat, rd, 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
            if (exp >= 0 && rw[exp]) mrdata = rd;
            n_chk++;
            if (exp < 0 || !ok || gid !== exp || ts !== ((r == 0) ? 1 : 2) ||
                ma !== a[exp] || mw !== d[exp] || mr !== rw[exp] || got !== mrdata || err) begin
                n_fail++; $display("FAIL random[%0d] mask=%b gid=%0d lat=%0d ok=%0b addr=%h rdata=%h err=%b want gid %0d addr %h rdata %h",
                                   r, mask, gid, ts, ok, ma, got, err, exp, (exp >= 0) ? a[exp] : 32'h0, mrdata);
            end
            note_done(exp);
            mask = bus.req | 3'($urandom_range(0, 7));
            if (mask == 3'b000) mask = 3'b001;
        end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        int c, stray, gid, ts, exp; logic [31:0] got, ma, mw, rd; logic mr; bit err, ok;
        @(negedge CLK);
        bus.req_rnw[2] = 1'b0; bus.req_addr[2*W +: W] = 32'h8; bus.req_wdata[2*W +: W] = 32'h55AA;
        bus.req[2] = 1'b1;
        c = 0;
        do begin @(negedge CLK); c++; end while (bus.m_start !== 1'b1 && c < 20);
        n_chk++;
        if (c !== 1 || grant_id !== 2'd2 || bus.m_addr !== 32'h8 || bus.m_wdata !== 32'h55AA || bus.m_rnw !== 1'b0) begin
            n_fail++; $display("FAIL timeout_issue lat=%0d gid=%0d addr=%h wdata=%h rnw=%b want 1/2/8/55aa/0",
                               c, grant_id, bus.m_addr, bus.m_wdata, bus.m_rnw);
        end
        c = 0;
        while (bus.req_done === 3'b000 && c < 40) begin
            @(negedge CLK); c++;
            if (c == TO) clr_timeout = 1'b1;
        end
        n_chk++;
        if (c !== TO + 1 || bus.req_done !== 3'b100 || bus.req_err !== 3'b100) begin
            n_fail++; $display("FAIL timeout_pulse cycles=%0d done=%b err=%b want %0d/100/100", c, bus.req_done, bus.req_err, TO + 1);
        end
        n_chk++;
        if (timeout_flag !== 1'b1 || bus.rdata !== 32'h0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_state tflag=%b rdata=%h busy=%b want 1/0/1", timeout_flag, bus.rdata, busy);
        end
        clr_timeout = 1'b0;
        bus.req[2] = 1'b0;
        bus.req_rnw[0] = 1'b1; bus.req[0] = 1'b1;
        mrdata = '0;
        stray = 0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge CLK);
            if (bus.m_start !== 1'b0 || bus.req_done !== 3'b000) stray++;
            if (j == 5) begin bus.m_done = 1'b1; bus.m_rdata = 32'hCAFEF00D; end
        end
        @(negedge CLK);
        bus.m_done = 1'b0; bus.m_rdata = '0;
        n_chk++;
        if (stray !== 0 || busy !== 1'b0 || bus.rdata !== 32'h0 || bus.req_done !== 3'b000 || timeout_flag !== 1'b1) begin
            n_fail++; $display("FAIL timeout_drain stray=%0d busy=%b rdata=%h done=%b tflag=%b want 0/0/0/000/1",
                               stray, busy, bus.rdata, bus.req_done, timeout_flag);
        end
        exp = ref_pick(bus.req, mptr);
        rd = $urandom;
        run_xfer(2, rd, 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
        n_chk++;
        if (!ok || gid !== exp || ts !== 1 || got !== rd || err) begin
            n_fail++; $display("FAIL after_drain gid=%0d lat=%0d ok=%0b rdata=%h err=%b want %0d/1/1/%h/0", gid, ts, ok, got, err, exp, rd);
        end
        note_done(exp); mrdata = rd;
        @(negedge CLK); clr_timeout = 1'b1;
        @(negedge CLK); clr_timeout = 1'b0;
        n_chk++;
        if (timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL clr_timeout tflag=%b want 0", timeout_flag);
        end
    endtask

    task automatic test_done_at_timeout();
        int gid, ts, exp; logic [31:0] got, ma, mw, rd; logic mr; bit err, ok;
        @(negedge CLK);
        bus.req_rnw[0] = 1'b1; bus.req[0] = 1'b1;
        exp = ref_pick(bus.req, mptr);
        rd = $urandom;
        run_xfer(TO, rd, 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
        n_chk++;
        if (!ok || gid !== exp || got !== rd || err !== 1'b0 || timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL done_at_deadline ok=%0b gid=%0d rdata=%h err=%b tflag=%b want 1/%0d/%h/0/0",
                               ok, gid, got, err, timeout_flag, exp, rd);
        end
        note_done(exp); mrdata = rd;
    endtask

    task automatic test_reset_mid();
        int c, gid, ts, exp; logic [31:0] got, ma, mw; logic mr; bit err, ok;
        @(negedge CLK);
        bus.req_rnw[1] = 1'b0; bus.req[1] = 1'b1;
        c = 0;
        do begin @(negedge CLK); c++; end while (bus.m_start !== 1'b1 && c < 20);
        repeat (3) @(negedge CLK);
        n_chk++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++; $display("FAIL mid_wait busy=%b gid=%0d want 1/1", busy, grant_id);
        end
        #2 RST = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || bus.m_start !== 1'b0 || grant_id !== 2'd0 || bus.m_addr !== 32'h0 ||
            bus.rdata !== 32'h0 || bus.req_done !== 3'b000 || timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL async_reset busy=%b start=%b gid=%0d addr=%h rdata=%h done=%b want all 0",
                               busy, bus.m_start, grant_id, bus.m_addr, bus.rdata, bus.req_done);
        end
        bus.m_done = 1'b1;
        @(negedge CLK);
        bus.m_done = 1'b0;
        RST = 1'b0;
        bus.req = 3'b011;
        mptr = 0;
        n_chk++;
        if (bus.req_done !== 3'b000) begin
            n_fail++; $display("FAIL reset_no_done done=%b want 000", bus.req_done);
        end
        exp = ref_pick(bus.req, mptr);
        run_xfer(2, $urandom, 3'b000, 1'b1, gid, got, ts, err, ok, ma, mr, mw);
        n_chk++;
        if (!ok || gid !== exp || ts !== 1 || err) begin
            n_fail++; $display("FAIL post_reset_grant ok=%0b gid=%0d lat=%0d err=%b want 1/%0d/1/0", ok, gid, ts, err, exp);
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_hipri();
        test_random();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end
endmodule
